// File: rtl/bcd_xs3_seq_converter.sv
// Serial multi-digit BCD <-> excess-3 converter, one digit per clock, LSD first.
// The input word is captured once, converted digit by digit and held until drained.
module bcd_xs3_seq_converter #(
    parameter int unsigned DIGITS   = 4,
    parameter logic [3:0]  ERR_CODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_mode,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  any_err
);

    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic [4*DIGITS-1:0]   word_q;
    logic                  mode_q;
    logic [4*DIGITS-1:0]   res_q;
    logic [DIGITS-1:0]     err_q;
    logic                  out_valid_q;

    logic [3:0]            dig_d;
    logic [3:0]            nib_d;
    logic                  nib_err_d;

    // Conversion of the digit currently selected by idx_q.
    always_comb begin
        dig_d     = word_q[{idx_q, 2'b00} +: 4];
        nib_d     = ERR_CODE;
        nib_err_d = 1'b1;
        if (!mode_q) begin
            if (dig_d <= 4'd9) begin
                nib_d     = dig_d + 4'd3;
                nib_err_d = 1'b0;
            end
        end else begin
            if ((dig_d >= 4'd3) && (dig_d <= 4'd12)) begin
                nib_d     = dig_d - 4'd3;
                nib_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            mode_q      <= 1'b0;
            res_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        word_q  <= in_data;
                        mode_q  <= in_mode;
                        res_q   <= '0;
                        err_q   <= '0;
                        idx_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    res_q[{idx_q, 2'b00} +: 4] <= nib_d;
                    err_q[idx_q]               <= nib_err_d;
                    idx_q                      <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_mode  = mode_q;
    assign err_mask  = err_q;
    assign any_err   = |err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_converter.sv
// Directed bench for the serial BCD/XS3 converter: a 4-digit instance for the
// word-level cases and a 1-digit instance for the per-value digit sweep.
module tb_bcd_xs3_seq_converter;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, any_err;
    logic [15:0] in_data, out_data;
    logic [3:0]  err_mask;

    logic        in_valid1, in_ready1, in_mode1, out_valid1, out_ready1, out_mode1, any_err1;
    logic [3:0]  in_data1, out_data1;
    logic [0:0]  err_mask1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    bcd_xs3_seq_converter #(.DIGITS(4), .ERR_CODE(4'hF)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .err_mask(err_mask), .any_err(any_err)
    );

    bcd_xs3_seq_converter #(.DIGITS(1), .ERR_CODE(4'hF)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_mode(in_mode1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_mode(out_mode1), .err_mask(err_mask1), .any_err(any_err1)
    );

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one word through the 4-digit instance with out_ready held high.
    task automatic run_word4(input logic mode, input logic [15:0] data,
                             input logic [15:0] exp_data, input logic [3:0] exp_err);
        int unsigned cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("w4_in_ready_before", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_mode  = ~mode;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w4_latency", 64'(cyc), 64'd4);
        check("w4_out_data", {48'd0, out_data}, {48'd0, exp_data});
        check("w4_err_mask", {60'd0, err_mask}, {60'd0, exp_err});
        check("w4_any_err", {63'd0, any_err}, {63'd0, |exp_err});
        check("w4_out_mode", {63'd0, out_mode}, {63'd0, mode});
        check("w4_in_ready_busy", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("w4_drain_valid", {63'd0, out_valid}, 64'd0);
        check("w4_drain_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_word1(input logic mode, input logic [3:0] data,
                             input logic [3:0] exp_data, input logic exp_err);
        int unsigned cyc;
        in_valid1 = 1'b1;
        in_data1  = data;
        in_mode1  = mode;
        @(negedge clk);
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w1_latency", 64'(cyc), 64'd1);
        check("w1_out_data", {60'd0, out_data1}, {60'd0, exp_data});
        check("w1_err", {63'd0, err_mask1[0]}, {63'd0, exp_err});
        check("w1_any_err", {63'd0, any_err1}, {63'd0, exp_err});
        @(negedge clk);
        check("w1_drain_ready", {63'd0, in_ready1}, 64'd1);
    endtask

    initial begin
        logic [3:0] e_nib;
        logic       e_err;
        int unsigned cyc;

        vecs[0] = '{mode: 1'b0, data: 16'h1234, exp_data: 16'h4567, exp_err: 4'b0000};
        vecs[1] = '{mode: 1'b1, data: 16'h4567, exp_data: 16'h1234, exp_err: 4'b0000};
        vecs[2] = '{mode: 1'b1, data: 16'hC003, exp_data: 16'h9FF0, exp_err: 4'b0110};
        vecs[3] = '{mode: 1'b0, data: 16'h9A05, exp_data: 16'hCF38, exp_err: 4'b0100};
        vecs[4] = '{mode: 1'b1, data: 16'hFD21, exp_data: 16'hFFFF, exp_err: 4'b1111};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; in_mode1 = 1'b0; out_ready1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {48'd0, out_data}, 64'd0);
        check("rst_err_mask", {60'd0, err_mask}, 64'd0);
        check("rst_any_err", {63'd0, any_err}, 64'd0);
        check("rst_out_mode", {63'd0, out_mode}, 64'd0);

        for (int i = 0; i < 5; i++)
            run_word4(vecs[i].mode, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err);

        // Backpressure: result must hold and a second word must be refused.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; in_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'd4);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 16'h0000;
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_data", {48'd0, out_data}, 64'h4567);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_valid", {63'd0, out_valid}, 64'd0);
        check("bp_drain_ready", {63'd0, in_ready}, 64'd1);
        run_word4(1'b0, 16'h0000, 16'h3333, 4'b0000);

        // Reset while idx=2 during conversion.
        in_valid = 1'b1; in_data = 16'h5678; in_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_out_data", {48'd0, out_data}, 64'd0);
        check("mid_rst_err_mask", {60'd0, err_mask}, 64'd0);
        check("mid_rst_any_err", {63'd0, any_err}, 64'd0);
        check("mid_rst_out_mode", {63'd0, out_mode}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mid_rst_no_valid", {63'd0, out_valid}, 64'd0);
        end
        run_word4(1'b0, 16'h5678, 16'h89AB, 4'b0000);

        // Single-digit sweep of every nibble value in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 16; d++) begin
                if (m == 0) begin
                    e_err = (d > 9);
                    e_nib = e_err ? 4'hF : 4'(d + 3);
                end else begin
                    e_err = (d < 3) || (d > 12);
                    e_nib = e_err ? 4'hF : 4'(d - 3);
                end
                run_word1(m[0], 4'(d), e_nib, e_err);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
